// File: rtl/sudoku_entry_if.sv
// Bus bundle between the Sudoku entry controller and its surroundings
// (recogniser, buttons, board mask on the input side; solver write
// protocol on the output side).
interface sudoku_entry_if;
  logic        i_load_req;
  logic [80:0] i_board_blank;
  logic        i_btn_up;
  logic        i_btn_down;
  logic        i_btn_left;
  logic        i_btn_right;
  logic        i_btn_clear;
  logic        i_digit_valid;
  logic [3:0]  i_digit;
  logic        o_digit_ready;
  logic        o_start;
  logic        o_read;
  logic [3:0]  o_row;
  logic [3:0]  o_col;
  logic [3:0]  o_data;
  logic        o_reject;
  logic        o_busy;

  modport slave (
    input  i_load_req, i_board_blank, i_btn_up, i_btn_down, i_btn_left,
           i_btn_right, i_btn_clear, i_digit_valid, i_digit,
    output o_digit_ready, o_start, o_read, o_row, o_col, o_data, o_reject,
           o_busy
  );

  modport master (
    output i_load_req, i_board_blank, i_btn_up, i_btn_down, i_btn_left,
           i_btn_right, i_btn_clear, i_digit_valid, i_digit,
    input  o_digit_ready, o_start, o_read, o_row, o_col, o_data, o_reject,
           o_busy
  );
endinterface

// File: rtl/sudoku_entry_ctrl.sv
// Cursor and entry controller in front of the Sudoku solver.
// Converts button pulses and recognised digits into the solver's
// start/read/row/col/data write protocol, protecting clue cells.
// Optional feature: define SUDOKU_SKIP_FIXED_EN to make cursor moves
// skip over fixed (clue) cells along the direction of travel.
module sudoku_entry_ctrl #(
  parameter int DIGIT_MAX = 9
) (
  input  logic          clk,
  input  logic          reset,
  sudoku_entry_if.slave bus
);

  localparam logic [3:0] LP_DMAX = 4'(DIGIT_MAX);

`ifdef SUDOKU_SKIP_FIXED_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_WRITE, S_SKIP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_WRITE} state_t;
`endif

  // Direction codes: 0 up, 1 down, 2 left, 3 right. Returns {row, col}.
  function automatic logic [7:0] f_step(input logic [1:0] dir,
                                        input logic [3:0] row,
                                        input logic [3:0] col);
    logic [3:0] v_r;
    logic [3:0] v_c;
    v_r = row;
    v_c = col;
    case (dir)
      2'd0:    v_r = (row == 4'd0) ? 4'd8 : row - 4'd1;
      2'd1:    v_r = (row == 4'd8) ? 4'd0 : row + 4'd1;
      2'd2:    v_c = (col == 4'd0) ? 4'd8 : col - 4'd1;
      default: v_c = (col == 4'd8) ? 4'd0 : col + 4'd1;
    endcase
    return {v_r, v_c};
  endfunction

  // Linear cell index row*9+col, 0..80.
  function automatic logic [6:0] f_idx(input logic [3:0] row,
                                       input logic [3:0] col);
    return ({3'd0, row} * 7'd9) + {3'd0, col};
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_row, w_row_nxt;
  logic [3:0] r_col, w_col_nxt;
  logic [3:0] r_data, w_data_nxt;
  logic       r_reject, w_reject_nxt;

  logic [1:0] w_mv_dir;
  logic [7:0] w_mv_tgt;
  logic       w_any_btn;
  logic       w_cur_blank;
  logic       w_digit_ok;

  assign w_any_btn   = bus.i_btn_up | bus.i_btn_down | bus.i_btn_left | bus.i_btn_right;
  assign w_mv_dir    = bus.i_btn_up   ? 2'd0 :
                       bus.i_btn_down ? 2'd1 :
                       bus.i_btn_left ? 2'd2 : 2'd3;
  assign w_mv_tgt    = f_step(w_mv_dir, r_row, r_col);
  assign w_cur_blank = bus.i_board_blank[f_idx(r_row, r_col)];
  assign w_digit_ok  = (bus.i_digit != 4'd0) && (bus.i_digit <= LP_DMAX);

`ifdef SUDOKU_SKIP_FIXED_EN
  logic [1:0] r_dir, w_dir_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] w_skip_tgt;
  logic       w_mv_blank;
  logic       w_skip_blank;

  assign w_skip_tgt   = f_step(r_dir, r_row, r_col);
  assign w_mv_blank   = bus.i_board_blank[f_idx(w_mv_tgt[7:4], w_mv_tgt[3:0])];
  assign w_skip_blank = bus.i_board_blank[f_idx(w_skip_tgt[7:4], w_skip_tgt[3:0])];
`endif

  // State and cursor/data registers; reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= 4'd0;
      r_col    <= 4'd0;
      r_data   <= 4'd0;
      r_reject <= 1'b0;
`ifdef SUDOKU_SKIP_FIXED_EN
      r_dir    <= 2'd0;
      r_cnt    <= 3'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_data   <= w_data_nxt;
      r_reject <= w_reject_nxt;
`ifdef SUDOKU_SKIP_FIXED_EN
      r_dir    <= w_dir_nxt;
      r_cnt    <= w_cnt_nxt;
`endif
    end
  end

  // Next-state: EDIT priority is load > digit > clear > move.
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_data_nxt   = r_data;
    w_reject_nxt = 1'b0;
`ifdef SUDOKU_SKIP_FIXED_EN
    w_dir_nxt    = r_dir;
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.i_load_req) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_row_nxt   = 4'd0;
        w_col_nxt   = 4'd0;
        w_data_nxt  = 4'd0;
        w_state_nxt = S_EDIT;
      end
      S_EDIT: begin
        if (bus.i_load_req) begin
          w_state_nxt = S_LOAD;
        end else if (bus.i_digit_valid) begin
          if (w_cur_blank && w_digit_ok) begin
            w_data_nxt  = bus.i_digit;
            w_state_nxt = S_WRITE;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else if (bus.i_btn_clear) begin
          if (w_cur_blank) begin
            w_data_nxt  = 4'd0;
            w_state_nxt = S_WRITE;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else if (w_any_btn) begin
          w_row_nxt = w_mv_tgt[7:4];
          w_col_nxt = w_mv_tgt[3:0];
`ifdef SUDOKU_SKIP_FIXED_EN
          if (!w_mv_blank) begin
            w_dir_nxt   = w_mv_dir;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_SKIP;
          end
`endif
        end
      end
      S_WRITE: begin
        w_state_nxt = S_EDIT;
      end
`ifdef SUDOKU_SKIP_FIXED_EN
      // One cell per cycle; the 8th extra step lands back on the origin.
      S_SKIP: begin
        w_row_nxt = w_skip_tgt[7:4];
        w_col_nxt = w_skip_tgt[3:0];
        w_cnt_nxt = r_cnt + 3'd1;
        if (w_skip_blank || (r_cnt == 3'd7)) w_state_nxt = S_EDIT;
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.o_start       = (r_state == S_LOAD);
  assign bus.o_read        = (r_state == S_WRITE);
  assign bus.o_digit_ready = (r_state == S_EDIT);
  assign bus.o_busy        = (r_state != S_IDLE) && (r_state != S_EDIT);
  assign bus.o_row         = r_row;
  assign bus.o_col         = r_col;
  assign bus.o_data        = r_data;
  assign bus.o_reject      = r_reject;

endmodule

// File: tb/tb_sudoku_entry_ctrl.sv
// Testbench for sudoku_entry_ctrl: directed scenarios plus randomized
// traffic, with a cell/cursor reference model feeding a scoreboard queue.
module tb_sudoku_entry_ctrl;
  localparam int DMAX = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sudoku_entry_if bus();

  sudoku_entry_ctrl #(.DIGIT_MAX(DMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;   // 0 start, 1 write, 2 reject
    int r;
    int c;
    int d;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  m_valid = 0;
  int  m_mode = 0;   // 0 idle, 1 load, 2 edit, 3 write, 4 skip
  int  m_r = 0;
  int  m_c = 0;
  int  m_sdir = 0;
  int  m_sn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_blank(input int r, input int c);
    return bus.i_board_blank[r*9+c];
  endfunction

  task automatic m_move(input int dir, inout int r, inout int c);
    case (dir)
      0: r = (r + 8) % 9;
      1: r = (r + 1) % 9;
      2: c = (c + 8) % 9;
      default: c = (c + 1) % 9;
    endcase
  endtask

  task automatic push(input int kind, input int r, input int c, input int d);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.r = r; e.c = c; e.d = d;
    q.push_back(e);
  endtask

  // Reference model: evaluates the inputs seen at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_valid = 1; m_mode = 0; m_r = 0; m_c = 0;
    end else if (m_valid) begin
      case (m_mode)
        0: if (bus.i_load_req) begin push(0, 0, 0, 0); m_mode = 1; end
        1: begin m_r = 0; m_c = 0; m_mode = 2; end
        2: begin
          if (bus.i_load_req) begin
            push(0, 0, 0, 0); m_mode = 1;
          end else if (bus.i_digit_valid) begin
            if (m_blank(m_r, m_c) && bus.i_digit >= 1 && bus.i_digit <= DMAX) begin
              push(1, m_r, m_c, int'(bus.i_digit)); m_mode = 3;
            end else push(2, 0, 0, 0);
          end else if (bus.i_btn_clear) begin
            if (m_blank(m_r, m_c)) begin push(1, m_r, m_c, 0); m_mode = 3; end
            else push(2, 0, 0, 0);
          end else if (bus.i_btn_up | bus.i_btn_down | bus.i_btn_left | bus.i_btn_right) begin
            m_sdir = bus.i_btn_up ? 0 : bus.i_btn_down ? 1 : bus.i_btn_left ? 2 : 3;
            m_move(m_sdir, m_r, m_c);
`ifdef SUDOKU_SKIP_FIXED_EN
            if (!m_blank(m_r, m_c)) begin m_mode = 4; m_sn = 0; end
`endif
          end
        end
        3: m_mode = 2;
        default: begin
          m_move(m_sdir, m_r, m_c);
          m_sn++;
          if (m_blank(m_r, m_c) || m_sn == 8) m_mode = 2;
        end
      endcase
    end
  end

  // Monitor: pops expected strobes and compares all visible outputs.
  initial forever begin : mon
    ev_t e;
    bit es, ew, ej;
    @(negedge clk);
    if (m_valid) begin
      es = 0; ew = 0; ej = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("stale_event", 32'(e.cyc), 32'(cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        es = (e.kind == 0); ew = (e.kind == 1); ej = (e.kind == 2);
      end
      chk("start", 32'(bus.o_start), 32'(es));
      chk("read", 32'(bus.o_read), 32'(ew));
      chk("reject", 32'(bus.o_reject), 32'(ej));
      if (ew) begin
        chk("wr_row", 32'(bus.o_row), 32'(e.r));
        chk("wr_col", 32'(bus.o_col), 32'(e.c));
        chk("wr_data", 32'(bus.o_data), 32'(e.d));
      end
      chk("digit_ready", 32'(bus.o_digit_ready), 32'(m_mode == 2));
      chk("busy", 32'(bus.o_busy), 32'(m_mode == 1 || m_mode == 3 || m_mode == 4));
      if (m_mode != 1) begin
        chk("row", 32'(bus.o_row), 32'(m_r));
        chk("col", 32'(bus.o_col), 32'(m_c));
      end
    end
  end

  task automatic drive(input bit rst, input bit ld, input bit up, input bit dn,
                       input bit lf, input bit rt, input bit clr, input bit dv,
                       input logic [3:0] d);
    @(negedge clk);
    reset = rst;
    bus.i_load_req = ld;
    bus.i_btn_up = up; bus.i_btn_down = dn; bus.i_btn_left = lf; bus.i_btn_right = rt;
    bus.i_btn_clear = clr; bus.i_digit_valid = dv; bus.i_digit = d;
  endtask

  // Drive one cycle of inputs and sample just after the edge that takes them.
  task automatic step(input bit ld, input bit up, input bit dn, input bit lf,
                      input bit rt, input bit clr, input bit dv, input logic [3:0] d);
    drive(1'b0, ld, up, dn, lf, rt, clr, dv, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    step(0, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic pos(input string nm, input int r, input int c);
    chk({nm, "_row"}, 32'(bus.o_row), 32'(r));
    chk({nm, "_col"}, 32'(bus.o_col), 32'(c));
  endtask

  initial begin
    int nb;
    bus.i_board_blank = '1;
    bus.i_load_req = 0; bus.i_btn_up = 0; bus.i_btn_down = 0; bus.i_btn_left = 0;
    bus.i_btn_right = 0; bus.i_btn_clear = 0; bus.i_digit_valid = 0; bus.i_digit = 0;

    repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    @(posedge clk); #1;
    chk("rst_read", 32'(bus.o_read), 0);
    chk("rst_start", 32'(bus.o_start), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_ready", 32'(bus.o_digit_ready), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    pos("rst", 0, 0);

    // IDLE ignores buttons and digits.
    step(0, 1, 0, 1, 0, 1, 1, 4'd3);
    pos("idle", 0, 0);
    chk("idle_read", 32'(bus.o_read), 0);

    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("load_start", 32'(bus.o_start), 1);
    chk("load_busy", 32'(bus.o_busy), 1);
    idle1();
    chk("load_start_off", 32'(bus.o_start), 0);
    chk("edit_ready", 32'(bus.o_digit_ready), 1);
    chk("edit_busy", 32'(bus.o_busy), 0);
    pos("edit", 0, 0);

    // Wrap-around moves.
    step(0, 0, 0, 1, 0, 0, 0, 4'd0); pos("wrap_left", 0, 8);
    step(0, 1, 0, 0, 0, 0, 0, 4'd0); pos("wrap_up", 8, 8);
    step(0, 0, 0, 0, 1, 0, 0, 4'd0); pos("wrap_right", 8, 0);
    step(0, 0, 1, 0, 0, 0, 0, 4'd0); pos("wrap_down", 0, 0);

    // Digit write at (4,4).
    repeat (4) step(0, 0, 1, 0, 0, 0, 0, 4'd0);
    repeat (4) step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd7);
    chk("w7_read", 32'(bus.o_read), 1);
    chk("w7_data", 32'(bus.o_data), 7);
    chk("w7_ready", 32'(bus.o_digit_ready), 0);
    pos("w7", 4, 4);
    idle1();
    chk("w7_read_off", 32'(bus.o_read), 0);

    // Fixed cell and out-of-range digits.
    bus.i_board_blank[0] = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    idle1();
    step(0, 0, 0, 0, 0, 0, 1, 4'd5);
    chk("fixed_reject", 32'(bus.o_reject), 1);
    chk("fixed_read", 32'(bus.o_read), 0);
    idle1();
    chk("reject_once", 32'(bus.o_reject), 0);
    step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    chk("zero_reject", 32'(bus.o_reject), 1);
    step(0, 0, 0, 0, 0, 0, 1, 4'd10);
    chk("ten_reject", 32'(bus.o_reject), 1);
    chk("ten_read", 32'(bus.o_read), 0);
    step(0, 0, 0, 1, 0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd0);
    chk("clr_fixed_reject", 32'(bus.o_reject), 1);
    step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd0);
    chk("clr_read", 32'(bus.o_read), 1);
    chk("clr_data", 32'(bus.o_data), 0);

    // Digit beats clear and move in the same cycle.
    idle1();
    step(0, 0, 0, 0, 1, 1, 1, 4'd3);
    chk("prio_read", 32'(bus.o_read), 1);
    chk("prio_data", 32'(bus.o_data), 3);
    pos("prio", 0, 1);
    idle1();
    pos("prio_after", 0, 1);

    // Held digit_valid: second cycle lands in WRITE and is ignored.
    step(0, 0, 0, 0, 0, 0, 1, 4'd4);
    step(0, 0, 0, 0, 0, 0, 1, 4'd6);
    chk("b2b_read_off", 32'(bus.o_read), 0);
    idle1();

    // Reset in the middle of a write.
    step(0, 0, 0, 0, 0, 0, 1, 4'd2);
    chk("midw_read", 32'(bus.o_read), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    @(posedge clk); #1;
    chk("midw_rst_read", 32'(bus.o_read), 0);
    chk("midw_rst_busy", 32'(bus.o_busy), 0);

`ifdef SUDOKU_SKIP_FIXED_EN
    bus.i_board_blank = '1;
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    idle1();
    step(0, 0, 1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    pos("skip_origin", 2, 1);
    for (int k = 18; k < 27; k++) bus.i_board_blank[k] = (k == 24);
    step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    nb = int'(bus.o_busy);
    repeat (8) begin idle1(); nb += int'(bus.o_busy); end
    chk("skip_busy", 32'(nb), 4);
    pos("skip_end", 2, 6);
    for (int k = 18; k < 27; k++) bus.i_board_blank[k] = 1'b1;
    repeat (5) step(0, 0, 0, 1, 0, 0, 0, 4'd0);
    for (int k = 18; k < 27; k++) bus.i_board_blank[k] = 1'b0;
    step(0, 0, 0, 0, 1, 0, 0, 4'd0);
    nb = int'(bus.o_busy);
    repeat (10) begin idle1(); nb += int'(bus.o_busy); end
    chk("skip_full_busy", 32'(nb), 8);
    pos("skip_full_end", 2, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0)
        for (int k = 0; k < 81; k++) bus.i_board_blank[k] = ($urandom_range(0, 9) < 6);
      drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)));
    end
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
